pcap_dma_buffer: RTL

- Sits directly downstream of pcap_core and consumes pcap_dat_o, pcap_dat_valid_o, pcap_done_o and pcap_actv_o.
- Buffers captured words in a FIFO and hands them to the DMA engine as length-tagged bursts.
- Flushes a final short burst when the capture completes.
- Drives the backpressure signal that feeds pcap_core's dma_full_i.

---
 rtl/pcap_dma_buffer_if.sv | 32 +++
 rtl/pcap_dma_buffer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pcap_dma_buffer_if.sv
// Bundle of capture-side and DMA-side signals around pcap_dma_buffer.
// slave is the buffer's view; master is the view of whatever drives it.
interface pcap_dma_buffer_if #(
  parameter int unsigned FIFO_AW = 11
) ();
  logic [31:0]      pcap_dat_i;
  logic             pcap_dat_valid_i;
  logic             pcap_done_i;
  logic             pcap_actv_i;
  logic             dma_full_o;
  logic             dma_req_o;
  logic             dma_ack_i;
  logic [15:0]      dma_len_o;
  logic             dma_last_o;
  logic [31:0]      dma_dat_o;
  logic             dma_dat_valid_o;
  logic             dma_dat_ready_i;
  logic             overflow_o;
  logic [FIFO_AW:0] level_o;

  modport slave (
    input  pcap_dat_i, pcap_dat_valid_i, pcap_done_i, pcap_actv_i, dma_ack_i, dma_dat_ready_i,
    output dma_full_o, dma_req_o, dma_len_o, dma_last_o, dma_dat_o, dma_dat_valid_o,
           overflow_o, level_o
  );

  modport master (
    output pcap_dat_i, pcap_dat_valid_i, pcap_done_i, pcap_actv_i, dma_ack_i, dma_dat_ready_i,
    input  dma_full_o, dma_req_o, dma_len_o, dma_last_o, dma_dat_o, dma_dat_valid_o,
           overflow_o, level_o
  );
endinterface

// File: rtl/pcap_dma_buffer.sv
// Capture FIFO feeding the DMA engine as length-tagged bursts; a pending capture-done
// request flushes whatever remains as a final (possibly zero-length) burst.
module pcap_dma_buffer #(
  parameter int unsigned FIFO_AW     = 11,
  parameter int unsigned BURST_LEN   = 256,
  parameter int unsigned FULL_MARGIN = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  pcap_dma_buffer_if.slave bus
);
  localparam int unsigned        Depth    = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   DepthLvl = (FIFO_AW + 1)'(Depth);
  localparam logic [FIFO_AW:0]   BurstLvl = (FIFO_AW + 1)'(BURST_LEN);
  localparam logic [FIFO_AW:0]   FullLvl  = (FIFO_AW + 1)'(Depth - FULL_MARGIN);
  localparam logic [FIFO_AW:0]   LvlOne   = 1;
  localparam logic [FIFO_AW-1:0] PtrOne   = 1;

  typedef enum logic [1:0] {StIdle, StReq, StXfer} state_e;

  state_e             state_q, state_d;
  logic [31:0]        mem_q [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic [15:0]        len_q, len_d, cnt_q, cnt_d;
  logic [31:0]        ddat_q, ddat_d;
  logic               last_q, last_d, dvalid_q, dvalid_d;
  logic               done_q, done_d, full_q, full_d, ovf_q, ovf_d, actv_q;
  logic               wr_en, pop, clr_done;

  assign wr_en = bus.pcap_dat_valid_i && (level_q != DepthLvl);

  // Burst sequencer; length and last flag are frozen when leaving IDLE.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    dvalid_d = dvalid_q;
    ddat_d   = ddat_q;
    rd_ptr_d = rd_ptr_q;
    pop      = 1'b0;
    clr_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (level_q >= BurstLvl) begin
          state_d = StReq;
          len_d   = 16'(BURST_LEN);
          last_d  = done_q && (level_q == BurstLvl);
        end else if (done_q) begin
          state_d = StReq;
          len_d   = 16'(level_q);
          last_d  = 1'b1;
        end
      end
      StReq: begin
        if (bus.dma_ack_i) begin
          clr_done = last_q;
          if (len_q != 16'd0) begin
            state_d  = StXfer;
            cnt_d    = len_q;
            dvalid_d = 1'b1;
            ddat_d   = mem_q[rd_ptr_q];
          end else begin
            state_d = StIdle;
          end
        end
      end
      StXfer: begin
        if (dvalid_q && bus.dma_dat_ready_i) begin
          pop      = 1'b1;
          rd_ptr_d = rd_ptr_q + PtrOne;
          cnt_d    = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            dvalid_d = 1'b0;
            state_d  = StIdle;
          end else begin
            ddat_d = mem_q[rd_ptr_d];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + PtrOne : wr_ptr_q;
    level_d  = level_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + LvlOne;
      2'b01:   level_d = level_q - LvlOne;
      default: level_d = level_q;
    endcase
    full_d = (level_d >= FullLvl);
    ovf_d  = ovf_q;
    if (bus.pcap_actv_i && !actv_q) ovf_d = 1'b0;
    if (bus.pcap_dat_valid_i && !wr_en) ovf_d = 1'b1;
    done_d = (done_q && !clr_done) || bus.pcap_done_i;
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.pcap_dat_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      ddat_q   <= '0;
      last_q   <= 1'b0;
      dvalid_q <= 1'b0;
      done_q   <= 1'b0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      actv_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      ddat_q   <= ddat_d;
      last_q   <= last_d;
      dvalid_q <= dvalid_d;
      done_q   <= done_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      actv_q   <= bus.pcap_actv_i;
    end
  end

  assign bus.dma_req_o       = (state_q == StReq);
  assign bus.dma_len_o       = len_q;
  assign bus.dma_last_o      = last_q;
  assign bus.dma_dat_o       = ddat_q;
  assign bus.dma_dat_valid_o = dvalid_q;
  assign bus.dma_full_o      = full_q;
  assign bus.overflow_o      = ovf_q;
  assign bus.level_o         = level_q;
endmodule
